// File: rtl/tuart_cmd_decode.sv
// SUMP-style command decoder: turns UART command words into LogIP config registers,
// control pulses and a 4-byte ID reply. Optional XON/XOFF gating via TUART_CMD_XONOFF_EN.
module tuart_cmd_decode #(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned CMD_WIDTH_WORDS = 5,
    parameter int unsigned NUM_STAGES      = 4,
    parameter logic [31:0] ID_WORD         = "1ALS"
) (
    input  logic                               clk_i,
    input  logic                               rst_in,
    input  logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] cmd_i,
    input  logic                               cmd_stb_i,
    output logic                               soft_rst_o,
    output logic                               arm_o,
    output logic [NUM_STAGES*32-1:0]           stg_mask_o,
    output logic [NUM_STAGES*32-1:0]           stg_val_o,
    output logic [NUM_STAGES*32-1:0]           stg_cfg_o,
    output logic [23:0]                        div_o,
    output logic [15:0]                        read_cnt_o,
    output logic [15:0]                        delay_cnt_o,
    output logic [7:0]                         flags_o,
    output logic [DATA_BITS-1:0]               tx_data_o,
    output logic                               tx_stb_o,
    input  logic                               tx_busy_i
`ifdef TUART_CMD_XONOFF_EN
    ,
    output logic                               xoff_o
`endif
);

    localparam int unsigned STG_W = NUM_STAGES * 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic                 soft_rst_q, soft_rst_d;
    logic                 arm_q, arm_d;
    logic [STG_W-1:0]     stg_mask_q, stg_mask_d;
    logic [STG_W-1:0]     stg_val_q, stg_val_d;
    logic [STG_W-1:0]     stg_cfg_q, stg_cfg_d;
    logic [23:0]          div_q, div_d;
    logic [15:0]          read_cnt_q, read_cnt_d;
    logic [15:0]          delay_cnt_q, delay_cnt_d;
    logic [7:0]           flags_q, flags_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_stb_q, tx_stb_d;
    logic                 xoff_q, xoff_d;

    logic [7:0]           op_c;
    logic [31:0]          pay_c;
    logic [7:0]           id_byte_c;
    logic                 xoff_hold_c;

    assign op_c  = cmd_i[7:0];
    assign pay_c = cmd_i[39:8];

`ifdef TUART_CMD_XONOFF_EN
    assign xoff_hold_c = xoff_q;
    assign xoff_o      = xoff_q;
`else
    assign xoff_hold_c = 1'b0;
`endif

    // Signature goes out MSB byte first
    always_comb begin
        case (idx_q)
            2'd0:    id_byte_c = ID_WORD[31:24];
            2'd1:    id_byte_c = ID_WORD[23:16];
            2'd2:    id_byte_c = ID_WORD[15:8];
            default: id_byte_c = ID_WORD[7:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            soft_rst_q  <= 1'b0;
            arm_q       <= 1'b0;
            stg_mask_q  <= '0;
            stg_val_q   <= '0;
            stg_cfg_q   <= '0;
            div_q       <= 24'd0;
            read_cnt_q  <= 16'd0;
            delay_cnt_q <= 16'd0;
            flags_q     <= 8'd0;
            tx_data_q   <= '0;
            tx_stb_q    <= 1'b0;
            xoff_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            soft_rst_q  <= soft_rst_d;
            arm_q       <= arm_d;
            stg_mask_q  <= stg_mask_d;
            stg_val_q   <= stg_val_d;
            stg_cfg_q   <= stg_cfg_d;
            div_q       <= div_d;
            read_cnt_q  <= read_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            flags_q     <= flags_d;
            tx_data_q   <= tx_data_d;
            tx_stb_q    <= tx_stb_d;
            xoff_q      <= xoff_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        soft_rst_d  = 1'b0;
        arm_d       = 1'b0;
        stg_mask_d  = stg_mask_q;
        stg_val_d   = stg_val_q;
        stg_cfg_d   = stg_cfg_q;
        div_d       = div_q;
        read_cnt_d  = read_cnt_q;
        delay_cnt_d = delay_cnt_q;
        flags_d     = flags_q;
        tx_data_d   = tx_data_q;
        tx_stb_d    = 1'b0;
        xoff_d      = xoff_q;

        // ID reply sequencer; GAP gives the transmitter a cycle to raise busy
        case (state_q)
            IDLE: ;
            SEND: begin
                if (!tx_busy_i && !xoff_hold_c) begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = DATA_BITS'(id_byte_c);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = SEND;
                end
            end
            default: begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end
        endcase

        if (cmd_stb_i) begin
            if (!op_c[7]) begin
                case (op_c[6:0])
                    7'h00: begin
                        soft_rst_d  = 1'b1;
                        stg_mask_d  = '0;
                        stg_val_d   = '0;
                        stg_cfg_d   = '0;
                        div_d       = 24'd0;
                        read_cnt_d  = 16'd0;
                        delay_cnt_d = 16'd0;
                        flags_d     = 8'd0;
                        xoff_d      = 1'b0;
                        tx_stb_d    = 1'b0;
                        idx_d       = 2'd0;
                        state_d     = IDLE;
                    end
                    7'h01: arm_d = 1'b1;
                    7'h02: begin
                        if (state_q == IDLE) begin
                            idx_d   = 2'd0;
                            state_d = SEND;
                        end
                    end
`ifdef TUART_CMD_XONOFF_EN
                    7'h11: xoff_d = 1'b0;
                    7'h13: xoff_d = 1'b1;
`endif
                    default: ;
                endcase
            end else if (op_c[6:4] == 3'b100) begin
                // Stage writes: s = op[3:2], k = op[1:0]; k=3 and absent stages fall through
                for (int unsigned j = 0; j < NUM_STAGES; j++) begin
                    if (op_c[3:2] == 2'(j)) begin
                        case (op_c[1:0])
                            2'd0:    stg_mask_d[32*j +: 32] = pay_c;
                            2'd1:    stg_val_d[32*j +: 32]  = pay_c;
                            2'd2:    stg_cfg_d[32*j +: 32]  = pay_c;
                            default: ;
                        endcase
                    end
                end
            end else begin
                case (op_c[6:0])
                    7'h00: div_d = pay_c[23:0];
                    7'h01: begin
                        read_cnt_d  = pay_c[15:0];
                        delay_cnt_d = pay_c[31:16];
                    end
                    7'h02: flags_d = pay_c[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign soft_rst_o  = soft_rst_q;
    assign arm_o       = arm_q;
    assign stg_mask_o  = stg_mask_q;
    assign stg_val_o   = stg_val_q;
    assign stg_cfg_o   = stg_cfg_q;
    assign div_o       = div_q;
    assign read_cnt_o  = read_cnt_q;
    assign delay_cnt_o = delay_cnt_q;
    assign flags_o     = flags_q;
    assign tx_data_o   = tx_data_q;
    assign tx_stb_o    = tx_stb_q;

endmodule

// File: tb/tb_tuart_cmd_decode.sv
// Directed bench for tuart_cmd_decode (two trigger stages) with a busy-for-10-cycles transmitter model.
module tb_tuart_cmd_decode;

    localparam int unsigned NS = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [39:0]     cmd;
    logic            cmd_stb;
    logic            soft_rst, arm, tx_stb, tx_busy;
    logic [NS*32-1:0] stg_mask, stg_val, stg_cfg;
    logic [23:0]     div;
    logic [15:0]     read_cnt, delay_cnt;
    logic [7:0]      flags, tx_data;
`ifdef TUART_CMD_XONOFF_EN
    logic            xoff;
`endif

    int checks   = 0;
    int failures = 0;
    int stb_cnt  = 0;
    int busy_cnt = 0;
    logic [7:0] exp_q[$];

    tuart_cmd_decode #(.NUM_STAGES(NS)) dut (
        .clk_i(clk), .rst_in(rst_n), .cmd_i(cmd), .cmd_stb_i(cmd_stb),
        .soft_rst_o(soft_rst), .arm_o(arm),
        .stg_mask_o(stg_mask), .stg_val_o(stg_val), .stg_cfg_o(stg_cfg),
        .div_o(div), .read_cnt_o(read_cnt), .delay_cnt_o(delay_cnt), .flags_o(flags),
        .tx_data_o(tx_data), .tx_stb_o(tx_stb), .tx_busy_i(tx_busy)
`ifdef TUART_CMD_XONOFF_EN
        , .xoff_o(xoff)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for 10 cycles after each send request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        busy_cnt <= 0;
        else if (tx_stb)   busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every send request must be expected and must not overlap busy
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_stb === 1'b1) begin
            stb_cnt++;
            check("stb_while_busy", 128'(tx_busy), 128'(0));
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_stb observed=%0h expected=none", tx_data);
            end
            if (exp_q.size() > 0) check("tx_byte", 128'(tx_data), 128'(exp_q.pop_front()));
        end
    end

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] p);
        @(negedge clk);
        cmd     = {p, op};
        cmd_stb = 1'b1;
        @(negedge clk);
        cmd_stb = 1'b0;
        cmd     = 40'h55_AAAA_5500;
    endtask

    task automatic wait_q_empty(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s observed=%0d_pending expected=0_pending", tag, exp_q.size());
        end
    endtask

    task automatic push_id();
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h53);
    endtask

    initial begin
        rst_n   = 1'b0;
        cmd     = '0;
        cmd_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_soft_rst", 128'(soft_rst), 128'(0));
        check("rst_arm", 128'(arm), 128'(0));
        check("rst_stg_mask", 128'(stg_mask), 128'(0));
        check("rst_stg_val", 128'(stg_val), 128'(0));
        check("rst_stg_cfg", 128'(stg_cfg), 128'(0));
        check("rst_div", 128'(div), 128'(0));
        check("rst_counts", 128'({read_cnt, delay_cnt}), 128'(0));
        check("rst_flags", 128'(flags), 128'(0));
        check("rst_tx", 128'({tx_data, tx_stb}), 128'(0));
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_no_stb", 128'(stb_cnt), 128'(0));

        // Stage register writes
        send_cmd(8'hC0, 32'h0000_FFFF);
        check("mask_s0", 128'(stg_mask), 128'(64'h0000_0000_0000_FFFF));
        send_cmd(8'hC5, 32'hDEAD_BEEF);
        check("val_s1", 128'(stg_val), 128'(64'hDEAD_BEEF_0000_0000));
        check("mask_kept", 128'(stg_mask), 128'(64'h0000_0000_0000_FFFF));
        send_cmd(8'hC6, 32'h1234_5678);
        check("cfg_s1", 128'(stg_cfg), 128'(64'h1234_5678_0000_0000));
        send_cmd(8'hCC, 32'hFFFF_FFFF);
        send_cmd(8'hC8, 32'hFFFF_FFFF);
        send_cmd(8'hC3, 32'hFFFF_FFFF);
        send_cmd(8'h83, 32'hFFFF_FFFF);
        check("ign_mask", 128'(stg_mask), 128'(64'h0000_0000_0000_FFFF));
        check("ign_val", 128'(stg_val), 128'(64'hDEAD_BEEF_0000_0000));
        check("ign_cfg", 128'(stg_cfg), 128'(64'h1234_5678_0000_0000));
        check("ign_misc", 128'({div, read_cnt, delay_cnt, flags}), 128'(0));

        // Scalar registers
        send_cmd(8'h81, 32'h0010_0020);
        check("read_cnt", 128'(read_cnt), 128'(16'h0020));
        check("delay_cnt", 128'(delay_cnt), 128'(16'h0010));
        send_cmd(8'h80, 32'hFF12_3456);
        check("div", 128'(div), 128'(24'h123456));
        send_cmd(8'h82, 32'hFFFF_FFA5);
        check("flags", 128'(flags), 128'(8'hA5));

        // Strobe low: cmd contents ignored
        @(negedge clk);
        cmd = {32'h0000_0000, 8'h80};
        repeat (2) @(negedge clk);
        check("no_stb_ignored", 128'(div), 128'(24'h123456));

        send_cmd(8'h01, 32'h0);
        check("arm_pulse", 128'({arm, soft_rst}), 128'(2'b10));
        @(negedge clk);
        check("arm_end", 128'(arm), 128'(0));

        send_cmd(8'h00, 32'hFFFF_FFFF);
        check("soft_rst_pulse", 128'({soft_rst, arm}), 128'(2'b10));
        check("soft_clr_stg", 128'({stg_mask, stg_val, stg_cfg}), 128'(0));
        check("soft_clr_misc", 128'({div, read_cnt, delay_cnt, flags}), 128'(0));
        @(negedge clk);
        check("soft_rst_end", 128'(soft_rst), 128'(0));

        // ID reply, with a redundant 0x02 and a register write mid-stream
        push_id();
        send_cmd(8'h02, 32'h0);
        repeat (15) @(negedge clk);
        send_cmd(8'h02, 32'h0);
        send_cmd(8'h82, 32'h0000_003C);
        check("flags_mid_id", 128'(flags), 128'(8'h3C));
        wait_q_empty(300, "id_stream");
        repeat (40) @(negedge clk);
        check("id_stb_total", 128'(stb_cnt), 128'(4));

        // Abort after the first byte
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h31);
        send_cmd(8'h02, 32'h0);
        wait_q_empty(50, "abort_first");
        send_cmd(8'h00, 32'h0);
        repeat (100) @(negedge clk);
        check("abort_stb_total", 128'(stb_cnt), 128'(5));
        check("abort_flags", 128'(flags), 128'(0));

`ifdef TUART_CMD_XONOFF_EN
        send_cmd(8'h13, 32'h0);
        check("xoff_set", 128'(xoff), 128'(1));
        send_cmd(8'h02, 32'h0);
        repeat (40) @(negedge clk);
        check("xoff_hold", 128'(stb_cnt), 128'(5));
        send_cmd(8'h11, 32'h0);
        check("xoff_clr", 128'(xoff), 128'(0));
        push_id();
        wait_q_empty(300, "xon_stream");
        repeat (20) @(negedge clk);
        check("xon_stb_total", 128'(stb_cnt), 128'(9));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
